// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR sequencing controller.
// Holds the FSM state encoding and the default geometry of the filter.
package fir_seq_pkg;

    localparam int NTAPS_DEF = 32;
    localparam int DW_DEF    = 16;

    // Tap index width; a single-tap filter still needs a 1-bit select.
    function automatic int tap_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAP_W = tap_w(NTAPS_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        MAC   = 3'd2,
        DONE  = 3'd3,
        FLUSH = 3'd4
    } state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample, result and datapath-control signals between the FIR controller and its surroundings.
// master = upstream/downstream environment, slave = the controller.
interface fir_seq_ctrl_if import fir_seq_pkg::*; #(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF
);
    localparam int TW = tap_w(NTAPS);

    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 flush;
    logic                 shift_en;
    logic        [DW-1:0] shift_din;
    logic        [TW-1:0] tap_sel;
    logic                 mac_clr;
    logic                 mac_en;
    logic                 out_valid;
    logic                 out_ready;
    logic                 warm;
    logic                 busy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, shift_en, shift_din, tap_sel, mac_clr, mac_en,
               out_valid, warm, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, shift_en, shift_din, tap_sel, mac_clr, mac_en,
               out_valid, warm, busy
    );

endinterface

// File: rtl/fir_tap_counter.sv
// Modulo-N cycle counter shared by the MAC sweep and the flush sweep.
// tc flags the last count; an enabled count at tc wraps back to zero.
module fir_tap_counter import fir_seq_pkg::*; #(
    parameter int N = NTAPS_DEF,
    parameter int W = tap_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(N - 1));

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR: shifts one sample into the delay line,
// sweeps NTAPS taps through the MAC, presents the result, and zero-fills on flush.
module fir_seq_ctrl import fir_seq_pkg::*; #(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    fir_seq_ctrl_if.slave  bus
);

    localparam int TW = tap_w(NTAPS);
    localparam int FW = $clog2(NTAPS + 1);

    state_t        state, state_d;
    logic [TW-1:0] cnt;
    logic          tc;
    logic          cnt_load, cnt_en;
    logic          accept;
    logic [FW-1:0] fill, fill_d;
    logic [DW-1:0] shift_din_d;
    logic [TW-1:0] tap_sel_d;

    fir_tap_counter #(.N(NTAPS), .W(TW)) u_tap_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt),
        .tc    (tc)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        fill_d      = fill;

        case (state)
            IDLE: begin
                // flush wins over a sample offered in the same cycle
                if (bus.flush) begin
                    state_d = FLUSH;
                end else if (bus.in_valid && bus.in_ready) begin
                    state_d = SHIFT;
                    accept  = 1'b1;
                end
            end
            SHIFT:   state_d = MAC;
            MAC:     if (tc) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            FLUSH:   if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_load    = (state == IDLE) || (state == SHIFT) || (state == DONE);
        cnt_en      = (state == MAC) || (state == FLUSH);
        tap_sel_d   = (state == MAC && !tc) ? cnt + TW'(1) : '0;
        shift_din_d = accept ? bus.in_data : '0;

        if (state == IDLE && bus.flush) begin
            fill_d = '0;
        end else if (state == SHIFT && fill != FW'(NTAPS)) begin
            fill_d = fill + FW'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fill          <= '0;
            bus.in_ready  <= 1'b0;
            bus.shift_en  <= 1'b0;
            bus.shift_din <= '0;
            bus.tap_sel   <= '0;
            bus.mac_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.warm      <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_d;
            fill          <= fill_d;
            bus.in_ready  <= (state_d == IDLE) && !bus.flush;
            bus.shift_en  <= (state_d == SHIFT) || (state_d == FLUSH);
            bus.shift_din <= shift_din_d;
            bus.tap_sel   <= tap_sel_d;
            bus.mac_clr   <= (state_d == SHIFT);
            bus.mac_en    <= (state_d == MAC);
            bus.out_valid <= (state_d == DONE);
            bus.warm      <= (fill_d == FW'(NTAPS));
            bus.busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: single sample timing, result back-pressure,
// flush priority, back-to-back fill to warm, and reset aborting a MAC sweep.
module tb_fir_seq_ctrl;

    localparam int NTAPS = 32;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fir_seq_ctrl_if #(.NTAPS(NTAPS), .DW(DW)) bus ();

    fir_seq_ctrl #(.NTAPS(NTAPS), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are observed and inputs changed on the falling edge.
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  1'b0);
        check({tag, "_shift_en"},  bus.shift_en,  1'b0);
        check({tag, "_shift_din"}, bus.shift_din, 16'h0);
        check({tag, "_tap_sel"},   bus.tap_sel,   5'd0);
        check({tag, "_mac_clr"},   bus.mac_clr,   1'b0);
        check({tag, "_mac_en"},    bus.mac_en,    1'b0);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_warm"},      bus.warm,      1'b0);
        check({tag, "_busy"},      bus.busy,      1'b0);
    endtask

    initial begin
        int lat;
        int n_acc, n_res, nshift, last_acc, seen_ov;
        logic exp_warm;
        logic [DW-1:0] exp_data;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step(3);
        check_idle_zero("rst");
        rst = 1'b0;
        step();
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        check("post_rst_busy",     bus.busy,     1'b0);

        // Single sample: shift, 32 taps, result at cycle 34
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        lat = 0;
        step(); lat++;
        bus.in_valid = 1'b0;
        check("s1_shift_en",  bus.shift_en,  1'b1);
        check("s1_shift_din", bus.shift_din, 16'h1234);
        check("s1_mac_clr",   bus.mac_clr,   1'b1);
        check("s1_mac_en",    bus.mac_en,    1'b0);
        check("s1_in_ready",  bus.in_ready,  1'b0);
        check("s1_busy",      bus.busy,      1'b1);
        for (int i = 0; i < NTAPS; i++) begin
            step(); lat++;
            check("s1_mac_en",   bus.mac_en,   1'b1);
            check("s1_tap_sel",  bus.tap_sel,  32'(i));
            check("s1_mac_shift",bus.shift_en, 1'b0);
            check("s1_mac_clr0", bus.mac_clr,  1'b0);
            check("s1_mac_ov",   bus.out_valid,1'b0);
        end
        step(); lat++;
        check("s1_latency",      32'(lat),      32'd34);
        check("s1_out_valid",    bus.out_valid, 1'b1);
        check("s1_done_mac_en",  bus.mac_en,    1'b0);
        check("s1_done_tap_sel", bus.tap_sel,   5'd0);

        // Result held under back-pressure, then handshake back to IDLE
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready",  bus.in_ready,  1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        check("hs_out_valid", bus.out_valid, 1'b0);
        check("hs_in_ready",  bus.in_ready,  1'b1);
        check("hs_busy",      bus.busy,      1'b0);

        // Flush together with a sample: flush wins, 32 zero shifts
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_in_ready", bus.in_ready, 1'b0);
        for (int j = 0; j < NTAPS; j++) begin
            check("fl_shift_en",  bus.shift_en,  1'b1);
            check("fl_shift_din", bus.shift_din, 16'h0);
            check("fl_mac_en",    bus.mac_en,    1'b0);
            check("fl_mac_clr",   bus.mac_clr,   1'b0);
            check("fl_out_valid", bus.out_valid, 1'b0);
            check("fl_warm",      bus.warm,      1'b0);
            step();
        end
        check("fl_end_shift_en", bus.shift_en, 1'b0);
        check("fl_end_in_ready", bus.in_ready, 1'b1);
        check("fl_end_busy",     bus.busy,     1'b0);

        // 32 samples back-to-back with in_valid held high throughout
        n_acc = 0; n_res = 0; nshift = 0; last_acc = 0;
        exp_warm = 1'b0; exp_data = '0;
        for (int cyc = 0; cyc < 32 * 35 + 100 && n_res < 32; cyc++) begin
            check("b2b_warm", bus.warm, exp_warm);
            if (bus.shift_en) begin
                check("b2b_shift_din", bus.shift_din, exp_data);
                check("b2b_no_mac",    bus.mac_en,    1'b0);
                nshift++;
                if (nshift == 32) exp_warm = 1'b1;
            end
            if (bus.out_valid) n_res++;
            bus.in_valid = (n_acc < 32);
            bus.in_data  = 16'(32'hA000 + n_acc);
            if (bus.in_valid && bus.in_ready) begin
                exp_data = bus.in_data;
                if (n_acc > 0) check("b2b_interval", 32'(cyc - last_acc), 32'd35);
                last_acc = cyc;
                n_acc++;
            end
            step();
        end
        check("b2b_accepted", 32'(n_acc), 32'd32);
        check("b2b_results",  32'(n_res), 32'd32);
        check("b2b_idle_ready", bus.in_ready, 1'b1);
        check("b2b_idle_warm",  bus.warm,     1'b1);

        // Flush during MAC is ignored; reset at tap 10 aborts the result
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        step();
        bus.in_valid = 1'b0;
        step();
        check("ab_tap0", bus.tap_sel, 5'd0);
        step(5);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("ab_flush_ign_mac",   bus.mac_en,   1'b1);
        check("ab_flush_ign_tap",   bus.tap_sel,  5'd6);
        check("ab_flush_ign_shift", bus.shift_en, 1'b0);
        check("ab_flush_ign_warm",  bus.warm,     1'b1);
        step(4);
        check("ab_tap10", bus.tap_sel, 5'd10);
        rst = 1'b1;
        step();
        check_idle_zero("ab_rst");
        rst = 1'b0;
        step();
        check("ab_post_in_ready", bus.in_ready, 1'b1);
        check("ab_post_warm",     bus.warm,     1'b0);
        seen_ov = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid || bus.busy) seen_ov++;
            step();
        end
        check("ab_no_result", 32'(seen_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NTAPS, default 32: number of delay-line stages sequenced.
REQ-002 The block SHALL have parameter DW, default 16: sample width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: upstream sample offered.
REQ-006 The block SHALL have port in_data, input, DW: upstream sample, signed.
REQ-007 The block SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-008 The block SHALL have port flush, input, 1: request to zero the delay line.
REQ-009 The block SHALL have port shift_en, output, 1: drives the delay-line data_valid.
REQ-010 The block SHALL have port shift_din, output, DW: drives the delay-line din.
REQ-011 The block SHALL have port tap_sel, output, clog2(NTAPS): selects the tap for the MAC.
REQ-012 The block SHALL have port mac_clr, output, 1: clears the external accumulator.
REQ-013 The block SHALL have port mac_en, output, 1: accumulates the selected tap times its coefficient.
REQ-014 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-015 The block SHALL have port warm, output, 1: high once NTAPS real samples have entered since the last reset or flush.
REQ-016 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, MAC, DONE and FLUSH; all outputs SHALL be registered.
REQ-018 in_ready SHALL be high only in IDLE with flush low.
REQ-019 When IDLE, flush high takes priority over in_valid; on a simultaneous flush and in_valid, the sample SHALL NOT be accepted.
REQ-020 On acceptance at edge T: state SHALL go to SHIFT; shift_din SHALL equal in_data; shift_en=1 and mac_clr=1 for exactly the cycle after T.
REQ-021 MAC SHALL last exactly NTAPS cycles: mac_en=1, tap_sel=0,1,...,NTAPS-1 in order, shift_en=0.
REQ-022 After tap NTAPS-1 the FSM SHALL enter DONE: out_valid=1, held stable until out_ready=1 is sampled, then IDLE.
REQ-023 Latency SHALL be NTAPS+2 cycles from acceptance to the first out_valid cycle (34 at default); throughput is one sample per NTAPS+3 cycles with out_ready tied high.
REQ-024 out_valid with out_ready high SHALL return to IDLE on the next edge; a new sample is not accepted in the same cycle.
REQ-025 FLUSH SHALL last NTAPS cycles with shift_en=1 and shift_din=0; mac_en=0, mac_clr=0, out_valid=0 throughout; then IDLE.
REQ-026 A fill counter (0..NTAPS) SHALL increment on each accepted-sample shift, saturate at NTAPS and clear at FLUSH entry; warm = (count == NTAPS).
REQ-027 flush asserted outside IDLE SHALL be ignored, not queued; in_valid outside IDLE SHALL be back-pressured.
REQ-028 tap_sel SHALL wrap to 0 on leaving MAC and SHALL hold 0 outside MAC.
REQ-029 shift_en SHALL never be high in the same cycle as mac_en.

Reset
REQ-030 rst SHALL force IDLE and zero all outputs, tap_sel and the fill counter on the next edge, from any state including mid-MAC or mid-FLUSH.
REQ-031 After reset, in_ready SHALL be 1 on the first cycle after rst deasserts, if flush is low.
REQ-032 A result aborted by reset SHALL NOT be presented.

Structure
REQ-033 Package fir_seq_pkg SHALL hold the state enum, NTAPS/DW defaults and the tap-counter width constant.
REQ-034 One sub-module, fir_tap_counter (load, enable, terminal-count flag), SHALL be shared by MAC and FLUSH.

Verification
REQ-035 Reset, then one sample 16'h1234 -> shift_en one cycle with shift_din=16'h1234, mac_en 32 cycles with tap_sel 0..31, out_valid at cycle 34.
REQ-036 out_ready low for 5 cycles in DONE -> out_valid stays 1, in_ready stays 0; then IDLE one cycle after the handshake.
REQ-037 32 samples back-to-back, out_ready=1 -> warm rises after the 32nd shift; one sample accepted every 35 cycles.
REQ-038 flush and in_valid together in IDLE -> sample not taken; 32 zero shifts, warm=0, then in_ready=1.
REQ-039 rst at MAC tap 10 -> all outputs 0 next cycle, no out_valid, fill counter 0.
